// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the decode / ID-EX stage:
//   - RV32I major opcodes and funct3 encodings
//   - ALU operation, access-size and result-source enums
//   - ctrl_t: the control bundle carried through the ID/EX register
//   - alu_from_f3(): funct3 (+ alternate bit) to ALU operation
package riscv_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load / store funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_t;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef struct packed {
        alu_op_t     alu_control;
        logic        alu_srcA;
        logic        alu_srcB;
        logic        write_en;
        mem_size_t   type_control;
        logic        sign_ext_flag;
        result_src_t result_src;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic [2:0]  funct3;
        logic        valid;
        logic        illegal;
    } ctrl_t;

    // alt selects SUB/SRA; callers only set it where that encoding exists.
    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile.sv
// regfile
// REG_COUNT x DATA_WIDTH architectural register file.
//   clk, rst_n          : clock, asynchronous active-low reset (clears all entries)
//   raddr1_i, raddr2_i  : asynchronous read indices
//   rdata1_o, rdata2_o  : read data; x0 reads 0, same-cycle write is bypassed
//   we_i, waddr_i, wdata_i : synchronous write port; writes to x0 are dropped
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            raddr1_i,
    input  logic [4:0]            raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i
);

    localparam int IDX_W = $clog2(REG_COUNT);

    // Entry 0 is never stored; reads of x0 are forced to zero below.
    logic [DATA_WIDTH-1:0] regs_q [1:REG_COUNT-1];

    genvar gi;
    generate
        for (gi = 1; gi < REG_COUNT; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[gi] <= '0;
                end else if (we_i && (waddr_i == 5'(gi))) begin
                    regs_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

    // Write-through: a write landing on this edge is already visible to the
    // reader in the same cycle, so the pipeline register never captures stale data.
    always_comb begin
        rdata1_o = '0;
        if (raddr1_i != 5'd0) begin
            if (we_i && (waddr_i == raddr1_i)) begin
                rdata1_o = wdata_i;
            end else begin
                rdata1_o = regs_q[raddr1_i[IDX_W-1:0]];
            end
        end
    end

    always_comb begin
        rdata2_o = '0;
        if (raddr2_i != 5'd0) begin
            if (we_i && (waddr_i == raddr2_i)) begin
                rdata2_o = wdata_i;
            end else begin
                rdata2_o = regs_q[raddr2_i[IDX_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// Decode stage plus ID/EX pipeline register.
//   Inputs : instr_d, pc_d, pc4_d, valid_d (from fetch); stall, flush (hazard
//            unit); wb_en, wb_rd, wb_data (writeback into the register file).
//   Outputs: *_e registered operands, register indices and control bundle
//            consumed by execute; valid_e and illegal_e status.
// Reset is asynchronous active-low and clears every output and register.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_d,
    input  logic [DATA_WIDTH-1:0] pc_d,
    input  logic [DATA_WIDTH-1:0] pc4_d,
    input  logic                  valid_d,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] pc_e,
    output logic [DATA_WIDTH-1:0] pc4_e,
    output logic [DATA_WIDTH-1:0] r_out1_e,
    output logic [DATA_WIDTH-1:0] r_out2_e,
    output logic [DATA_WIDTH-1:0] imm_ext_e,
    output logic [4:0]            rs1_e,
    output logic [4:0]            rs2_e,
    output logic [4:0]            rd_e,
    output logic [3:0]            alu_control_e,
    output logic                  alu_srcA_e,
    output logic                  alu_srcB_e,
    output logic                  write_en_e,
    output logic [1:0]            type_control_e,
    output logic                  sign_ext_flag_e,
    output logic [1:0]            result_src_e,
    output logic                  reg_write_e,
    output logic                  branch_e,
    output logic                  jump_e,
    output logic [2:0]            funct3_e,
    output logic                  valid_e,
    output logic                  illegal_e
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [4:0] rs1, rs2, rd;

    assign opcode = instr_d[6:0];
    assign rd     = instr_d[11:7];
    assign f3     = instr_d[14:12];
    assign rs1    = instr_d[19:15];
    assign rs2    = instr_d[24:20];

    logic [DATA_WIDTH-1:0] r_out1_d, r_out2_d;

    regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (r_out1_d),
        .rdata2_o (r_out2_d),
        .we_i     (wb_en),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data)
    );

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    ctrl_t                 ctrl_d;
    logic [31:0]           imm32;
    logic [DATA_WIDTH-1:0] imm_d;
    logic                  supported;

    always_comb begin
        ctrl_d        = '0;
        imm32         = '0;
        supported     = 1'b1;
        ctrl_d.funct3 = f3;

        case (opcode)
            OPC_LUI: begin
                imm32              = {instr_d[31:12], 12'b0};
                ctrl_d.alu_control = ALU_PASSB;
                ctrl_d.alu_srcB    = 1'b1;
                ctrl_d.reg_write   = 1'b1;
            end
            OPC_AUIPC: begin
                imm32              = {instr_d[31:12], 12'b0};
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.alu_srcA    = 1'b1;
                ctrl_d.alu_srcB    = 1'b1;
                ctrl_d.reg_write   = 1'b1;
            end
            OPC_JAL: begin
                imm32 = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20],
                         instr_d[30:21], 1'b0};
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.alu_srcA    = 1'b1;
                ctrl_d.alu_srcB    = 1'b1;
                ctrl_d.result_src  = RES_PC4;
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.jump        = 1'b1;
            end
            OPC_JALR: begin
                imm32              = {{20{instr_d[31]}}, instr_d[31:20]};
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.alu_srcB    = 1'b1;
                ctrl_d.result_src  = RES_PC4;
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.jump        = 1'b1;
            end
            OPC_BRANCH: begin
                imm32 = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25],
                         instr_d[11:8], 1'b0};
                case (f3)
                    F3_BEQ, F3_BNE:   ctrl_d.alu_control = ALU_SUB;
                    F3_BLT, F3_BGE:   ctrl_d.alu_control = ALU_SLT;
                    F3_BLTU, F3_BGEU: ctrl_d.alu_control = ALU_SLTU;
                    default:          ctrl_d.alu_control = ALU_SUB;
                endcase
                ctrl_d.branch = 1'b1;
            end
            OPC_LOAD: begin
                imm32              = {{20{instr_d[31]}}, instr_d[31:20]};
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.alu_srcB    = 1'b1;
                ctrl_d.result_src  = RES_MEM;
                ctrl_d.reg_write   = 1'b1;
                case (f3)
                    F3_LB:   begin ctrl_d.type_control = SIZE_BYTE; ctrl_d.sign_ext_flag = 1'b1; end
                    F3_LH:   begin ctrl_d.type_control = SIZE_HALF; ctrl_d.sign_ext_flag = 1'b1; end
                    F3_LBU:  ctrl_d.type_control = SIZE_BYTE;
                    F3_LHU:  ctrl_d.type_control = SIZE_HALF;
                    default: begin ctrl_d.type_control = SIZE_WORD; ctrl_d.sign_ext_flag = 1'b1; end
                endcase
            end
            OPC_STORE: begin
                imm32              = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
                ctrl_d.alu_control = ALU_ADD;
                ctrl_d.alu_srcB    = 1'b1;
                ctrl_d.write_en    = 1'b1;
                case (f3[1:0])
                    2'b00:   ctrl_d.type_control = SIZE_BYTE;
                    2'b01:   ctrl_d.type_control = SIZE_HALF;
                    default: ctrl_d.type_control = SIZE_WORD;
                endcase
            end
            OPC_OP: begin
                ctrl_d.alu_control = alu_from_f3(f3, instr_d[30]);
                ctrl_d.reg_write   = 1'b1;
            end
            OPC_OP_IMM: begin
                imm32 = {{20{instr_d[31]}}, instr_d[31:20]};
                // Only SRAI uses bit 30 as an opcode bit; ADDI has no SUB form
                // and a negative immediate also sets bit 30.
                ctrl_d.alu_control = alu_from_f3(f3, (f3 == F3_SRL_SRA) && instr_d[30]);
                ctrl_d.alu_srcB    = 1'b1;
                ctrl_d.reg_write   = 1'b1;
            end
            default: supported = 1'b0;
        endcase

        // Nothing with an architectural side effect may escape from a
        // non-instruction or an unsupported opcode.
        if (!valid_d || !supported) begin
            ctrl_d.reg_write = 1'b0;
            ctrl_d.write_en  = 1'b0;
            ctrl_d.branch    = 1'b0;
            ctrl_d.jump      = 1'b0;
        end
        ctrl_d.valid   = valid_d;
        ctrl_d.illegal = valid_d && !supported;

        imm_d = DATA_WIDTH'($signed(imm32));
    end

    // ------------------------------------------------------------------
    // ID/EX register: flush beats stall beats capture
    // ------------------------------------------------------------------
    ctrl_t                 ctrl_q;
    logic [DATA_WIDTH-1:0] pc_q, pc4_q, r_out1_q, r_out2_q, imm_q;
    logic [4:0]            rs1_q, rs2_q, rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= '0;
            pc_q     <= '0;
            pc4_q    <= '0;
            r_out1_q <= '0;
            r_out2_q <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
        end else if (flush) begin
            ctrl_q   <= '0;
            pc_q     <= '0;
            pc4_q    <= '0;
            r_out1_q <= '0;
            r_out2_q <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
        end else if (!stall) begin
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            pc4_q    <= pc4_d;
            r_out1_q <= r_out1_d;
            r_out2_q <= r_out2_d;
            imm_q    <= imm_d;
            rs1_q    <= rs1;
            rs2_q    <= rs2;
            rd_q     <= rd;
        end
    end

    assign pc_e            = pc_q;
    assign pc4_e           = pc4_q;
    assign r_out1_e        = r_out1_q;
    assign r_out2_e        = r_out2_q;
    assign imm_ext_e       = imm_q;
    assign rs1_e           = rs1_q;
    assign rs2_e           = rs2_q;
    assign rd_e            = rd_q;
    assign alu_control_e   = ctrl_q.alu_control;
    assign alu_srcA_e      = ctrl_q.alu_srcA;
    assign alu_srcB_e      = ctrl_q.alu_srcB;
    assign write_en_e      = ctrl_q.write_en;
    assign type_control_e  = ctrl_q.type_control;
    assign sign_ext_flag_e = ctrl_q.sign_ext_flag;
    assign result_src_e    = ctrl_q.result_src;
    assign reg_write_e     = ctrl_q.reg_write;
    assign branch_e        = ctrl_q.branch;
    assign jump_e          = ctrl_q.jump;
    assign funct3_e        = ctrl_q.funct3;
    assign valid_e         = ctrl_q.valid;
    assign illegal_e       = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_d, pc_d, pc4_d;
    logic        valid_d, stall, flush, wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic [31:0] pc_e, pc4_e, r_out1_e, r_out2_e, imm_ext_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [3:0]  alu_control_e;
    logic        alu_srcA_e, alu_srcB_e, write_en_e;
    logic [1:0]  type_control_e, result_src_e;
    logic        sign_ext_flag_e, reg_write_e, branch_e, jump_e;
    logic [2:0]  funct3_e;
    logic        valid_e, illegal_e;

    int total = 0;
    int bad   = 0;

    // Every output concatenated, for all-zero checks.
    logic [194:0] all_out;
    assign all_out = {pc_e, pc4_e, r_out1_e, r_out2_e, imm_ext_e, rs1_e, rs2_e, rd_e,
                      alu_control_e, alu_srcA_e, alu_srcB_e, write_en_e, type_control_e,
                      sign_ext_flag_e, result_src_e, reg_write_e, branch_e, jump_e,
                      funct3_e, valid_e, illegal_e};

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_d(pc_d), .pc4_d(pc4_d),
        .valid_d(valid_d), .stall(stall), .flush(flush), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .pc_e(pc_e), .pc4_e(pc4_e), .r_out1_e(r_out1_e), .r_out2_e(r_out2_e),
        .imm_ext_e(imm_ext_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .alu_control_e(alu_control_e), .alu_srcA_e(alu_srcA_e), .alu_srcB_e(alu_srcB_e),
        .write_en_e(write_en_e), .type_control_e(type_control_e),
        .sign_ext_flag_e(sign_ext_flag_e), .result_src_e(result_src_e),
        .reg_write_e(reg_write_e), .branch_e(branch_e), .jump_e(jump_e),
        .funct3_e(funct3_e), .valid_e(valid_e), .illegal_e(illegal_e)
    );

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v);
        instr_d = ins;
        pc_d    = pc;
        pc4_d   = pc + 32'd4;
        valid_d = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("txn t=%0t instr=%h valid_d=%b stall=%b flush=%b wb=%b/x%0d/%h -> valid_e=%b alu=%h r1=%h r2=%h imm=%h",
                 $time, instr_d, valid_d, stall, flush, wb_en, wb_rd, wb_data,
                 valid_e, alu_control_e, r_out1_e, r_out2_e, imm_ext_e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        drive(32'h00500093, 32'h0, 1'b1);
        tick(); tick();
        total++; if (all_out !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_bypass();
        drive(32'h00500093, 32'h0, 1'b1);               // ADDI x1,x0,5
        tick();
        total++; if (imm_ext_e !== 32'd5) begin bad++; $display("FAIL addi_imm: got %h want %h", imm_ext_e, 32'd5); end
        total++; if ({alu_srcB_e, reg_write_e, rd_e, valid_e} !== {1'b1, 1'b1, 5'd1, 1'b1}) begin bad++; $display("FAIL addi_ctrl: got %b want %b", {alu_srcB_e, reg_write_e, rd_e, valid_e}, {1'b1, 1'b1, 5'd1, 1'b1}); end
        drive(32'h00108133, 32'h4, 1'b1);               // ADD x2,x1,x1 with x1=5 written back
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        tick();
        wb_en = 1'b0;
        total++; if (r_out1_e !== 32'd5) begin bad++; $display("FAIL add_bypass_r1: got %h want %h", r_out1_e, 32'd5); end
        total++; if (r_out2_e !== 32'd5) begin bad++; $display("FAIL add_bypass_r2: got %h want %h", r_out2_e, 32'd5); end
        total++; if ({alu_control_e, reg_write_e, alu_srcB_e} !== {4'b0000, 1'b1, 1'b0}) begin bad++; $display("FAIL add_ctrl: got %b want %b", {alu_control_e, reg_write_e, alu_srcB_e}, {4'b0000, 1'b1, 1'b0}); end
        total++; if ({pc_e, pc4_e} !== {32'h4, 32'h8}) begin bad++; $display("FAIL add_pc: got %h want %h", {pc_e, pc4_e}, {32'h4, 32'h8}); end
    endtask

    task automatic test_load();
        drive(32'h0080A183, 32'h8, 1'b1);               // LW x3,8(x1)
        tick();
        total++; if (r_out1_e !== 32'd5) begin bad++; $display("FAIL lw_x1_stored: got %h want %h", r_out1_e, 32'd5); end
        total++; if (imm_ext_e !== 32'd8) begin bad++; $display("FAIL lw_imm: got %h want %h", imm_ext_e, 32'd8); end
        total++; if ({result_src_e, type_control_e, sign_ext_flag_e, alu_srcB_e} !== {2'b01, 2'b00, 1'b1, 1'b1}) begin bad++; $display("FAIL lw_ctrl: got %b want %b", {result_src_e, type_control_e, sign_ext_flag_e, alu_srcB_e}, {2'b01, 2'b00, 1'b1, 1'b1}); end
        drive(32'h0080C183, 32'hC, 1'b1);               // LBU x3,8(x1)
        tick();
        total++; if ({type_control_e, sign_ext_flag_e, result_src_e} !== {2'b10, 1'b0, 2'b01}) begin bad++; $display("FAIL lbu_ctrl: got %b want %b", {type_control_e, sign_ext_flag_e, result_src_e}, {2'b10, 1'b0, 2'b01}); end
    endtask

    task automatic test_jal();
        drive(32'hFFDFF0EF, 32'h100, 1'b1);             // JAL x1,-4
        tick();
        total++; if (imm_ext_e !== 32'hFFFFFFFC) begin bad++; $display("FAIL jal_imm: got %h want %h", imm_ext_e, 32'hFFFFFFFC); end
        total++; if ({alu_srcA_e, alu_srcB_e, result_src_e, jump_e, reg_write_e, branch_e} !== {1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0}) begin bad++; $display("FAIL jal_ctrl: got %b want %b", {alu_srcA_e, alu_srcB_e, result_src_e, jump_e, reg_write_e, branch_e}, {1'b1, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0}); end
        total++; if ({pc_e, pc4_e} !== {32'h100, 32'h104}) begin bad++; $display("FAIL jal_pc: got %h want %h", {pc_e, pc4_e}, {32'h100, 32'h104}); end
    endtask

    task automatic test_branch();
        drive(32'h0020C463, 32'h104, 1'b1);             // BLT x1,x2,+8
        tick();
        total++; if (imm_ext_e !== 32'd8) begin bad++; $display("FAIL blt_imm: got %h want %h", imm_ext_e, 32'd8); end
        total++; if ({alu_control_e, branch_e, funct3_e, reg_write_e, alu_srcB_e} !== {4'b1000, 1'b1, 3'b100, 1'b0, 1'b0}) begin bad++; $display("FAIL blt_ctrl: got %b want %b", {alu_control_e, branch_e, funct3_e, reg_write_e, alu_srcB_e}, {4'b1000, 1'b1, 3'b100, 1'b0, 1'b0}); end
    endtask

    task automatic test_stall_flush();
        drive(32'h0073A223, 32'h200, 1'b1);             // SW x7,4(x7), x7 = 0
        tick();
        total++; if ({write_en_e, reg_write_e, imm_ext_e, type_control_e} !== {1'b1, 1'b0, 32'd4, 2'b00}) begin bad++; $display("FAIL sw_ctrl: got %h want %h", {write_en_e, reg_write_e, imm_ext_e, type_control_e}, {1'b1, 1'b0, 32'd4, 2'b00}); end
        stall = 1'b1;
        drive(32'h00500093, 32'h204, 1'b1);             // different instruction waiting
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
        for (int k = 0; k < 3; k++) begin
            tick();
            wb_en = 1'b0;
            total++; if ({valid_e, write_en_e, pc_e, r_out1_e, r_out2_e, imm_ext_e, rs2_e} !== {1'b1, 1'b1, 32'h200, 32'd0, 32'd0, 32'd4, 5'd7}) begin bad++; $display("FAIL stall_hold_%0d: got %h want %h", k, {valid_e, write_en_e, pc_e, r_out1_e, r_out2_e, imm_ext_e, rs2_e}, {1'b1, 1'b1, 32'h200, 32'd0, 32'd0, 32'd4, 5'd7}); end
        end
        flush = 1'b1;
        tick();
        total++; if (all_out !== '0) begin bad++; $display("FAIL flush_bubble: got %h want 0", all_out); end
        flush = 1'b0; stall = 1'b0;
        drive(32'h0073A223, 32'h208, 1'b1);
        tick();
        total++; if ({r_out1_e, r_out2_e} !== {32'h77, 32'h77}) begin bad++; $display("FAIL stall_wb_landed: got %h want %h", {r_out1_e, r_out2_e}, {32'h77, 32'h77}); end
    endtask

    task automatic test_x0_illegal();
        drive(32'h00500093, 32'h300, 1'b1);             // reads x0
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
        tick();
        wb_en = 1'b0;
        total++; if (r_out1_e !== 32'd0) begin bad++; $display("FAIL x0_bypass: got %h want 0", r_out1_e); end
        tick();
        total++; if (r_out1_e !== 32'd0) begin bad++; $display("FAIL x0_stored: got %h want 0", r_out1_e); end
        drive(32'h0000007F, 32'h304, 1'b1);
        tick();
        total++; if ({illegal_e, reg_write_e, write_en_e, valid_e} !== {1'b1, 1'b0, 1'b0, 1'b1}) begin bad++; $display("FAIL illegal_op: got %b want %b", {illegal_e, reg_write_e, write_en_e, valid_e}, {1'b1, 1'b0, 1'b0, 1'b1}); end
        drive(32'h00500093, 32'h308, 1'b0);
        tick();
        total++; if ({illegal_e, reg_write_e, valid_e} !== {1'b0, 1'b0, 1'b0}) begin bad++; $display("FAIL invalid_slot: got %b want %b", {illegal_e, reg_write_e, valid_e}, {1'b0, 1'b0, 1'b0}); end
    endtask

    task automatic test_reset_midrun();
        drive(32'h00000013, 32'h400, 1'b1);
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
        tick();
        wb_en = 1'b0;
        drive(32'h00028313, 32'h404, 1'b1);             // ADDI x6,x5,0
        tick();
        total++; if ({r_out1_e, rd_e} !== {32'h55, 5'd6}) begin bad++; $display("FAIL pre_reset_x5: got %h want %h", {r_out1_e, rd_e}, {32'h55, 5'd6}); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (all_out !== '0) begin bad++; $display("FAIL async_reset: got %h want 0", all_out); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if ({valid_e, rd_e, reg_write_e} !== {1'b1, 5'd6, 1'b1}) begin bad++; $display("FAIL post_reset_capture: got %b want %b", {valid_e, rd_e, reg_write_e}, {1'b1, 5'd6, 1'b1}); end
        total++; if (r_out1_e !== 32'd0) begin bad++; $display("FAIL post_reset_x5: got %h want 0", r_out1_e); end
    endtask

    initial begin
        test_reset();
        test_alu_bypass();
        test_load();
        test_jal();
        test_branch();
        test_stall_flush();
        test_x0_illegal();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage plus ID/EX pipeline register feeding `execute`. Accepts a fetched instruction with its PC, decodes it into the control bundle `execute` consumes, and reads operands from an internal 32-entry register file with write-through bypass. It also registers everything on one clock edge and honours stall and flush from the hazard logic. Writeback enters here through the register-file write port.

## Interface
- `DATA_WIDTH`, default 32: datapath width.
- `REG_COUNT`, default 32: architectural registers. Index width is `$clog2(REG_COUNT)`.
- `clk` in, 1: clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `instr_d` in, 32: instruction from fetch.
- `pc_d`, `pc4_d` in, DATA_WIDTH: PC of the instruction and PC+4.
- `valid_d` in, 1: `instr_d` is a real instruction.
- `stall` in, 1: hold the ID/EX register.
- `flush` in, 1: load a bubble into the ID/EX register.
- `wb_en` in, 1: register-file write enable.
- `wb_rd` in, 5: write index.
- `wb_data` in, DATA_WIDTH: write data.
- `pc_e`, `pc4_e`, `r_out1_e`, `r_out2_e`, `imm_ext_e` out, DATA_WIDTH: registered operands.
- `rs1_e`, `rs2_e`, `rd_e` out, 5: registered register indices, for forwarding.
- `alu_control_e` out, 4: ALU operation.
- `alu_srcA_e` out, 1: 0 selects rs1, 1 selects PC.
- `alu_srcB_e` out, 1: 0 selects rs2, 1 selects immediate.
- `write_en_e` out, 1: data-memory store.
- `type_control_e` out, 2: access size. 00 = word, 01 = half, 10 = byte.
- `sign_ext_flag_e` out, 1: sign-extend loaded data.
- `result_src_e` out, 2: result source. 00 = ALU, 01 = memory, 10 = pc4.
- `reg_write_e` out, 1: instruction writes `rd`.
- `branch_e`, `jump_e` out, 1: branch or jump class.
- `funct3_e` out, 3: branch condition.
- `valid_e` out, 1: the stage holds a real instruction.
- `illegal_e` out, 1: unsupported opcode.

## Operation
- Decode is combinational from `instr_d`.
  - Supported classes: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Immediate formats I/S/B/U/J are sign-extended to DATA_WIDTH.
- ALU codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU, 1010 PASSB.
- Per-class control:
  - LUI: PASSB, srcB = imm.
  - AUIPC: ADD, srcA = PC, srcB = imm.
  - JAL: ADD, srcA = PC, srcB = imm, result pc4, `jump_e` = 1.
  - JALR: ADD, srcA = rs1, srcB = imm, result pc4, `jump_e` = 1.
  - BEQ/BNE: SUB.
  - BLT/BGE: SLT.
  - BLTU/BGEU: SLTU.
- LOAD: `result_src` 01. `type_control` and `sign_ext_flag` come from funct3 (LBU/LHU give 0).
- STORE: `write_en` = 1, `reg_write` = 0.
- Illegal opcode or `valid_d` = 0:
  - Side-effect signals are zero: `reg_write`, `write_en`, `branch`, `jump`.
  - `illegal_e` = `valid_d` AND opcode unsupported.
- Register file:
  - Two async read ports, one sync write port.
  - x0 reads 0. Writes to x0 are ignored.
  - Bypass: if `wb_en` and `wb_rd` == rs (with rs ≠ 0), the read returns `wb_data` in the same cycle.
- ID/EX register update, per rising edge, in priority order:
  1. `flush`: bubble. `valid_e` = 0, all control outputs 0, data outputs 0.
  2. `stall`: hold all outputs.
  3. Otherwise: capture the decode results.
- Register-file writes happen regardless of `stall` and `flush`.

## Timing
- Reset, asynchronous on `rst_n` low:
  - Every output is 0.
  - All register-file entries are 0.
  - The register file also stays 0 while reset is held.
- Latency: `instr_d` to the `_e` outputs is 1 cycle.
- A writeback at edge N is visible to reads from edge N onward via the bypass. There are no stale reads.
- `flush` and `stall` together: `flush` wins.
- A stall held for K cycles holds the outputs for K edges. If `wb_en` targets a held instruction's source, the held `r_out` does NOT update; forwarding in execute covers that case.
- Reset deasserting mid-stream: the first edge after release captures the current inputs normally.

## Structure
- Package `riscv_pkg` holds:
  - opcode constants;
  - an enum for the ALU codes;
  - enums for `type_control` and `result_src`;
  - the funct3 constants.
- Sub-module `regfile`: REG_COUNT × DATA_WIDTH storage, async reset, x0 hardwire, write-through bypass.
- Decode stays inline in `id_ex_stage` as one `always_comb` block.

## Test plan
- Reset: assert `rst_n` = 0 mid-run → all outputs 0 immediately. Register x5 reads 0 afterwards.
- ADDI x1,x0,5 then ADD x2,x1,x1 (`instr_d` 0x00500093 then 0x00108133), with writeback of x1 = 5 in the second cycle → the second instruction gives `r_out1_e` = `r_out2_e` = 5, `alu_control_e` 0000, `reg_write_e` 1.
- LW x3,8(x1) (0x0080A183) → `imm_ext_e` 8, `result_src_e` 01, `type_control_e` 00, `sign_ext_flag_e` 1, `alu_srcB_e` 1. LBU gives `type_control_e` 10 and `sign_ext_flag_e` 0.
- JAL x1,-4 (0xFFDFF0EF) → `imm_ext_e` 0xFFFFFFFC, `alu_srcA_e` 1, `result_src_e` 10, `jump_e` 1.
- Stall for 3 cycles, then `flush` and `stall` together:
  - Outputs are held through the stall.
  - On the flush edge `valid_e` = 0 and `write_en_e`/`reg_write_e` = 0.
  - A writeback to x7 during the stall still lands.
- Write x0 = 0xDEADBEEF with `wb_en` → the x0 read stays 0. Opcode 0x7F with `valid_d` = 1 → `illegal_e` 1, `reg_write_e` 0.
